// File: rtl/dds_lut_load_ctrl.sv
// Purpose: round-robin sequencer that copies waveform tables from source memory into per-channel DDS lookup RAMs.
// Latency: LEN+3 clk from grant to idle; each lookup write lands 1 clk after its source read is accepted.
// Backpressure: src_waitrequest holds src_addr/idx and inserts write gaps only for the stalled cycles.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   address/chipselect/write_n/
//   writedata/readdata                4-word Avalon-MM slave (PENDING, SRC_BASE, LEN, STATUS); reads registered
//   hw_req                            single-cycle hardware reload requests, one per channel
//   src_rd/src_addr/src_waitrequest/
//   src_rdata                         source memory read port, data returns 1 clk after acceptance
//   lut_wr_en/ch/addr/data            lookup RAM write port
//   done_toggle                       per-channel completion toggle (to edge-capture PIO)
//   busy                              transfer in progress
// Optional: define DDS_LUT_CHECKSUM_EN to expose a 16-bit sum of written samples in STATUS[31:16].
module dds_lut_load_ctrl #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int SRC_AW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] hw_req,
  output logic              src_rd,
  output logic [SRC_AW-1:0] src_addr,
  input  logic              src_waitrequest,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              lut_wr_en,
  output logic [2:0]        lut_wr_ch,
  output logic [ADDR_W-1:0] lut_wr_addr,
  output logic [DATA_W-1:0] lut_wr_data,
  output logic [NUM_CH-1:0] done_toggle,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_XFER, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0]     LEN_MAX = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  logic [NUM_CH-1:0]   pending;
  logic [SRC_AW-1:0]   src_base;
  logic [ADDR_W:0]     len_reg;
  logic [SRC_AW-1:0]   base_lat;
  logic [ADDR_W:0]     len_lat;
  logic [2:0]          ch;
  logic [2:0]          last_grant;
  logic [ADDR_W:0]     idx;

  logic                cpu_wr, cpu_rd, accept;
  logic                rr_vld;
  logic [2:0]          rr_ch;
  logic [NUM_CH-1:0]   grant_oh, ch_oh, pending_nxt;
  logic [ADDR_W:0]     idx_n;
  logic [SRC_AW-1:0]   addr_first, addr_next;
  logic [31:0]         status, rd_mux;

  assign cpu_wr = chipselect && !write_n;
  assign cpu_rd = chipselect && write_n;
  assign accept = src_rd && !src_waitrequest;
  assign idx_n  = idx + IDX_ONE;

  // Source address is the base plus the channel number concatenated above the table index.
  assign addr_first = base_lat + SRC_AW'({ch, {ADDR_W{1'b0}}});
  assign addr_next  = base_lat + SRC_AW'({ch, idx_n[ADDR_W-1:0]});

  // The sample is only present on src_rdata during the write cycle; gate it so the port idles at 0.
  assign lut_wr_data = lut_wr_en ? src_rdata : '0;

  // Round-robin search starting one past the last completed channel.
  always_comb begin
    int         c;
    logic [2:0] ci;
    logic [7:0] pend8;
    rr_vld = 1'b0;
    rr_ch  = '0;
    c      = 0;
    ci     = '0;
    pend8  = 8'(pending);
    for (int i = 1; i <= NUM_CH; i++) begin
      c  = (int'(last_grant) + i) % NUM_CH;
      ci = c[2:0];
      if (!rr_vld && pend8[ci]) begin
        rr_vld = 1'b1;
        rr_ch  = ci;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    ch_oh    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_oh[i] = (rr_ch == 3'(i));
      ch_oh[i]    = (ch == 3'(i));
    end
  end

  // Grant clears first so a same-cycle request (CPU or hardware) re-pends the channel.
  always_comb begin
    pending_nxt = pending;
    if (state == S_IDLE && rr_vld) pending_nxt = pending_nxt & ~grant_oh;
    if (cpu_wr && address == 2'd0) begin
      if (writedata[31]) pending_nxt = '0;
      else               pending_nxt = pending_nxt | writedata[NUM_CH-1:0];
    end
    pending_nxt = pending_nxt | hw_req;
  end

`ifdef DDS_LUT_CHECKSUM_EN
  logic [15:0] cksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum <= '0;
    end else if (state == S_IDLE && rr_vld) begin
      cksum <= '0;
    end else if (lut_wr_en) begin
      cksum <= cksum + 16'(src_rdata);
    end
  end
`endif

  always_comb begin
    status = '0;
    status[0]              = busy;
    status[3:1]            = ch;
    status[8+NUM_CH-1:8]   = done_toggle;
`ifdef DDS_LUT_CHECKSUM_EN
    status[31:16]          = cksum;
`endif
  end

  always_comb begin
    case (address)
      2'd0:    rd_mux = 32'(pending);
      2'd1:    rd_mux = 32'(src_base);
      2'd2:    rd_mux = 32'(len_reg);
      default: rd_mux = status;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pending     <= '0;
      src_base    <= '0;
      len_reg     <= '0;
      base_lat    <= '0;
      len_lat     <= '0;
      ch          <= '0;
      last_grant  <= 3'(NUM_CH - 1);
      idx         <= '0;
      readdata    <= '0;
      src_rd      <= 1'b0;
      src_addr    <= '0;
      lut_wr_en   <= 1'b0;
      lut_wr_ch   <= '0;
      lut_wr_addr <= '0;
      done_toggle <= '0;
      busy        <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      lut_wr_en <= 1'b0;

      if (cpu_wr) begin
        case (address)
          2'd1: src_base <= writedata[SRC_AW-1:0];
          2'd2: len_reg  <= (writedata > LEN_MAX) ? LEN_MAX[ADDR_W:0] : writedata[ADDR_W:0];
          default: ;
        endcase
      end
      if (cpu_rd) readdata <= rd_mux;

      // Write stage trails the accepted read by one cycle, matching the source data latency.
      if (accept) begin
        lut_wr_en   <= 1'b1;
        lut_wr_ch   <= ch;
        lut_wr_addr <= idx[ADDR_W-1:0];
      end

      case (state)
        S_IDLE: begin
          if (rr_vld) begin
            state    <= S_GRANT;
            ch       <= rr_ch;
            base_lat <= src_base;
            len_lat  <= len_reg;
            busy     <= 1'b1;
          end
        end
        S_GRANT: begin
          idx <= '0;
          if (len_lat == '0) begin
            state <= S_DONE;
          end else begin
            state    <= S_XFER;
            src_rd   <= 1'b1;
            src_addr <= addr_first;
          end
        end
        S_XFER: begin
          if (accept) begin
            idx <= idx_n;
            if (idx_n == len_lat) begin
              src_rd <= 1'b0;
              state  <= S_DRAIN;
            end else begin
              src_addr <= addr_next;
            end
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          done_toggle <= done_toggle ^ ch_oh;
          last_grant  <= ch;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_lut_load_ctrl.sv
module tb_dds_lut_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [5:0]  hw_req;
  logic        src_rd;
  logic [15:0] src_addr;
  logic        src_waitrequest;
  logic [15:0] src_rdata;
  logic        lut_wr_en;
  logic [2:0]  lut_wr_ch;
  logic [9:0]  lut_wr_addr;
  logic [15:0] lut_wr_data;
  logic [5:0]  done_toggle;
  logic        busy;

  always #5 clk = ~clk;

  dds_lut_load_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .hw_req(hw_req),
    .src_rd(src_rd), .src_addr(src_addr), .src_waitrequest(src_waitrequest),
    .src_rdata(src_rdata), .lut_wr_en(lut_wr_en), .lut_wr_ch(lut_wr_ch),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .done_toggle(done_toggle),
    .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          busy_run = 0;
  logic        ck_mode = 1'b0;
  logic [15:0] ck_tab [4];
  logic [5:0]  exp_tog;
  logic [28:0] exp_q [$];

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } rg_t;

  typedef struct {
    int          ch;
    logic [15:0] base;
    int          len;
    int          exp_busy;
  } xf_t;

  rg_t rg_tab [8];
  xf_t xf_tab [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (ck_mode) return ck_tab[a[1:0]];
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Source memory: data returns one cycle after an accepted read, junk otherwise.
  always @(posedge clk)
    src_rdata <= (src_rd && !src_waitrequest) ? memf(src_addr) : 16'hDEAD;

  // Scoreboard + busy-run monitor.
  always @(negedge clk) begin
    logic [28:0] e;
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        busy_run = busy_cnt;
        busy_cnt = 0;
      end
      if (lut_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got ch=%0d addr=0x%0h data=0x%0h expected no write",
                   lut_wr_ch, lut_wr_addr, lut_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("lut_write", 32'({lut_wr_ch, lut_wr_addr, lut_wr_data}), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; hw_req = '0; src_waitrequest = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    exp_tog = '0;
    tick();
  endtask

  task automatic push_xfer(input int c, input logic [15:0] base, input int len);
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 16'(c << 10) + 16'(i);
      exp_q.push_back({3'(c), 10'(i), memf(a)});
    end
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int q = 0;
    int n = 0;
    while (n < budget && q < 3) begin
      tick();
      n++;
      if (!busy && exp_q.size() == 0) q++;
      else q = 0;
    end
    chk({name, "_completes"}, 32'(q >= 3), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        t0;
    int          n;

    address = '0; writedata = '0; chipselect = 1'b0; write_n = 1'b1;
    hw_req = '0; src_waitrequest = 1'b0; reset_n = 1'b0;
    ck_tab[0] = 16'hFFFF; ck_tab[1] = 16'h0002; ck_tab[2] = 16'h0010; ck_tab[3] = 16'h0000;

    rg_tab[0] = '{2'd1, 32'h0001_2345, 32'h0000_2345};
    rg_tab[1] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_FFFF};
    rg_tab[2] = '{2'd2, 32'h0000_07FF, 32'h0000_0400};
    rg_tab[3] = '{2'd2, 32'h0000_0400, 32'h0000_0400};
    rg_tab[4] = '{2'd2, 32'h0000_0401, 32'h0000_0400};
    rg_tab[5] = '{2'd2, 32'h0000_03FF, 32'h0000_03FF};
    rg_tab[6] = '{2'd2, 32'h8000_0005, 32'h0000_0400};
    rg_tab[7] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};

    xf_tab[0] = '{2, 16'h0100, 4, 7};
    xf_tab[1] = '{5, 16'hFF00, 3, 6};
    xf_tab[2] = '{0, 16'h1234, 1, 4};
    xf_tab[3] = '{4, 16'h0000, 5, 8};

    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_rd", 32'(src_rd), 32'd0);
    chk("rst_lut_wr_en", 32'(lut_wr_en), 32'd0);
    chk("rst_done_toggle", 32'(done_toggle), 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 32'd0);
    end

    // Register map vectors
    for (int i = 0; i < 8; i++) begin
      cpu_write(rg_tab[i].a, rg_tab[i].wd);
      cpu_read(rg_tab[i].a, d);
      chk($sformatf("reg_vec%0d", i), d, rg_tab[i].exp);
    end

    // Single-channel transfers
    for (int i = 0; i < 4; i++) begin
      cpu_write(2'd1, 32'(xf_tab[i].base));
      cpu_write(2'd2, 32'(xf_tab[i].len));
      push_xfer(xf_tab[i].ch, xf_tab[i].base, xf_tab[i].len);
      cpu_write(2'd0, 32'(1) << xf_tab[i].ch);
      wait_quiet(100, $sformatf("xfer%0d", i));
      exp_tog = exp_tog ^ 6'(1 << xf_tab[i].ch);
      chk($sformatf("xfer%0d_busy_clk", i), 32'(busy_run), 32'(xf_tab[i].exp_busy));
      chk($sformatf("xfer%0d_done_toggle", i), 32'(done_toggle), 32'(exp_tog));
    end

    // LEN=0: no writes, toggle two clocks after grant
    cpu_write(2'd2, 32'd0);
    cpu_write(2'd0, 32'h01);
    n = 0;
    while (n < 20 && !busy) begin tick(); n++; end
    chk("len0_grant_seen", 32'(busy), 32'd1);
    t0 = done_toggle[0];
    tick();
    chk("len0_toggle_grant_p1", 32'(done_toggle[0]), 32'(t0));
    tick();
    chk("len0_toggle_grant_p2", 32'(done_toggle[0]), 32'(!t0));
    exp_tog[0] = !t0;
    wait_quiet(20, "len0");
    chk("len0_busy_clk", 32'(busy_run), 32'd2);

    // Three-cycle source stall in the middle of a transfer
    cpu_write(2'd1, 32'h0040);
    cpu_write(2'd2, 32'd8);
    push_xfer(1, 16'h0040, 8);
    cpu_write(2'd0, 32'h02);
    n = 0;
    while (n < 20 && !lut_wr_en) begin tick(); n++; end
    chk("stall_first_write_seen", 32'(lut_wr_en), 32'd1);
    chk("stall_addr_pre", 32'(src_addr), 32'h0441);
    src_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_addr_hold%0d", k), 32'(src_addr), 32'h0441);
      chk($sformatf("stall_no_write%0d", k), 32'(lut_wr_en), 32'd0);
    end
    src_waitrequest = 1'b0;
    wait_quiet(60, "stall");
    exp_tog[1] = !exp_tog[1];
    chk("stall_busy_clk", 32'(busy_run), 32'd14);
    chk("stall_done_toggle", 32'(done_toggle), 32'(exp_tog));

    // PENDING set and clear while another channel is busy
    cpu_write(2'd1, 32'h0200);
    cpu_write(2'd2, 32'd32);
    push_xfer(3, 16'h0200, 32);
    cpu_write(2'd0, 32'h08);
    n = 0;
    while (n < 20 && !busy) begin tick(); n++; end
    cpu_write(2'd0, 32'h30);
    cpu_read(2'd0, d);
    chk("pend_set_during_busy", d, 32'h30);
    cpu_read(2'd3, d);
    chk("status_busy_ch3", 32'(d[15:0]), (32'(exp_tog) << 8) | 32'h7);
    cpu_write(2'd0, 32'h8000_0030);
    cpu_read(2'd0, d);
    chk("pend_clear", d, 32'h0);
    wait_quiet(100, "pend_clear_xfer");
    exp_tog[3] = !exp_tog[3];
    chk("pend_clear_done_toggle", 32'(done_toggle), 32'(exp_tog));

    // Grant order from reset, hardware re-request of channel 0
    do_reset();
    cpu_write(2'd1, 32'h0);
    cpu_write(2'd2, 32'd2);
    for (int c = 0; c < 6; c++) push_xfer(c, 16'h0000, 2);
    cpu_write(2'd0, 32'h3F);
    n = 0;
    while (n < 100 && !(lut_wr_en && lut_wr_ch == 3'd3)) begin tick(); n++; end
    chk("rr_ch3_reached", 32'(lut_wr_en && lut_wr_ch == 3'd3), 32'd1);
    hw_req = 6'h01;
    tick();
    hw_req = '0;
    push_xfer(0, 16'h0000, 2);
    wait_quiet(200, "rr");
    chk("rr_done_toggle", 32'(done_toggle), 32'h3E);

    // Reset during XFER of ch1 at idx 5
    cpu_write(2'd2, 32'd16);
    cpu_write(2'd1, 32'h0);
    push_xfer(1, 16'h0000, 5);
    cpu_write(2'd0, 32'h02);
    n = 0;
    while (n < 40 && !(lut_wr_en && lut_wr_addr == 10'd4)) begin tick(); n++; end
    chk("mid_idx4_write_seen", 32'(lut_wr_en), 32'd1);
    chk("mid_src_addr_idx5", 32'(src_addr), 32'h0405);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_src_rd", 32'(src_rd), 32'd0);
    chk("mid_rst_src_addr", 32'(src_addr), 32'd0);
    chk("mid_rst_lut_wr_en", 32'(lut_wr_en), 32'd0);
    chk("mid_rst_lut_wr_ch", 32'(lut_wr_ch), 32'd0);
    chk("mid_rst_lut_wr_addr", 32'(lut_wr_addr), 32'd0);
    chk("mid_rst_lut_wr_data", 32'(lut_wr_data), 32'd0);
    chk("mid_rst_done_toggle", 32'(done_toggle), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_readdata", readdata, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    exp_tog = '0;
    chk("mid_rst_sb_drained", 32'(exp_q.size()), 32'd0);
    cpu_read(2'd0, d);
    chk("mid_rst_pending", d, 32'd0);
    repeat (20) tick();
    chk("mid_rst_stays_idle", 32'(busy), 32'd0);

`ifdef DDS_LUT_CHECKSUM_EN
    ck_mode = 1'b1;
    cpu_write(2'd1, 32'h0);
    cpu_write(2'd2, 32'd3);
    push_xfer(0, 16'h0000, 3);
    cpu_write(2'd0, 32'h01);
    wait_quiet(40, "cksum");
    cpu_read(2'd3, d);
    chk("cksum_status_hi", 32'(d[31:16]), 32'h0011);
    chk("cksum_status_lo", 32'(d[15:0]), 32'h0100);
    ck_mode = 1'b0;
`else
    cpu_write(2'd1, 32'h10);
    cpu_write(2'd2, 32'd3);
    push_xfer(0, 16'h0010, 3);
    cpu_write(2'd0, 32'h01);
    wait_quiet(40, "status_final");
    cpu_read(2'd3, d);
    chk("status_hi_zero", 32'(d[31:16]), 32'h0);
    chk("status_lo", 32'(d[15:0]), 32'h0100);
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_lut_load_ctrl.md
Name: dds_lut_load_ctrl

Overview:
- Sequences waveform reloads into the per-channel DDS lookup RAMs.
- Up to NUM_CH channel reload requests (CPU or hardware) are round-robin arbitrated onto one source-memory read port and one lookup-RAM write port.
- Completion is signalled per channel as a level toggle on done_toggle, which feeds the 6-bit edge-capture PIO in_port for Nios II interrupts.
- Configured through a 4-word Avalon-MM slave.

Parameters:
- NUM_CH, 6, number of channels; max 8.
- ADDR_W, 10, lookup RAM index width per channel.
- DATA_W, 16, sample width.
- SRC_AW, 16, source memory word address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  slave word address
- chipselect  in  1  slave select
- write_n  in  1  slave write strobe, active low
- writedata  in  32  slave write data
- readdata  out  32  slave read data, registered
- hw_req  in  NUM_CH  single-cycle hardware reload requests
- src_rd  out  1  source read request
- src_addr  out  SRC_AW  source word address
- src_waitrequest  in  1  source stall
- src_rdata  in  DATA_W  source data, valid exactly 1 cycle after an accepted read
- lut_wr_en  out  1  lookup RAM write strobe
- lut_wr_ch  out  3  target channel
- lut_wr_addr  out  ADDR_W  lookup RAM index
- lut_wr_data  out  DATA_W  sample
- done_toggle  out  NUM_CH  inverts once per completed channel reload
- busy  out  1  transfer in progress

Behaviour:
- Reset: every output is 0, pending=0, FSM=IDLE, SRC_BASE=0, LEN=0, last_grant=NUM_CH-1 so channel 0 wins first.
- Register map, reads registered with 1-cycle latency:
  - 0 PENDING: read gives pending[NUM_CH-1:0]. Write ORs writedata[NUM_CH-1:0] into pending. If writedata[31]=1, pending is cleared instead and the set bits are ignored.
  - 1 SRC_BASE: bits [SRC_AW-1:0].
  - 2 LEN: bits [ADDR_W:0]. Values above 2^ADDR_W saturate to 2^ADDR_W.
  - 3 STATUS: [0]=busy, [3:1]=current channel, [8+NUM_CH-1:8]=done_toggle, [31:16]=0 (see Optional Feature).
- pending[n] is set by a CPU write or by hw_req[n]. It clears on the cycle channel n is granted. A request that arrives in that same cycle wins, so pending stays 1. A request for a channel already in progress re-pends it and it is serviced again later.
- FSM IDLE -> GRANT when pending!=0:
  - Round-robin search starting at last_grant+1 with wrap.
  - SRC_BASE and LEN are latched at grant. Register writes during a transfer affect only the next one.
  - busy=1 from GRANT until the end of DONE.
- GRANT -> XFER, or -> DONE directly if the latched LEN=0 (no writes are issued).
- XFER: src_rd=1, src_addr = SRC_BASE + {ch, idx} (modulo 2^SRC_AW).
  - idx advances on each accepted read (src_rd && !src_waitrequest).
  - One cycle after each accepted read: lut_wr_en=1 for exactly one cycle, lut_wr_addr=that read's idx, lut_wr_data=src_rdata, lut_wr_ch=ch.
  - After the LEN-th read is accepted: -> DRAIN.
- DRAIN: one cycle for the final write -> DONE.
- DONE: one cycle; done_toggle[ch] inverts; last_grant=ch; -> IDLE.
- Throughput: 1 word/clk without stall. Total LEN+3 clk from grant to IDLE.
- Reset mid-transfer: the transfer is aborted immediately, no further writes, done_toggle returns to 0.

Optional Feature:
- Macro: DDS_LUT_CHECKSUM_EN.
- When defined: a 16-bit accumulator is cleared at GRANT and adds the low 16 bits of each written sample (mod 2^16). It holds its value after DONE and is readable in STATUS[31:16].
- When undefined: STATUS[31:16] reads 0 and no accumulator logic exists.

Test Plan:
- SRC_BASE=0x0100, LEN=4, write PENDING=0x04 -> four writes: ch=2, addr 0..3, data=src[0x0900..0x0903]. done_toggle[2] 0->1. busy high 7 clk.
- PENDING write 0x3F from reset -> grant order 0,1,2,3,4,5. hw_req[0] during ch3 -> ch0 serviced after ch5.
- src_waitrequest high 3 clk mid-transfer -> src_addr and idx held. No lut_wr_en gap except the stalled cycles. All LEN samples written exactly once.
- LEN=0, PENDING=0x01 -> no lut_wr_en. done_toggle[0] inverts 2 clk after grant.
- reset_n low during XFER of ch1 at idx 5 -> all outputs 0 within the same cycle, pending=0. After release, no writes until a new request.
- With DDS_LUT_CHECKSUM_EN: LEN=3, samples 0xFFFF, 0x0002, 0x0010 -> STATUS[31:16]=0x0011.
